alien_hit_detector: RTL and testbench

ALIEN_HIT_DETECTOR -- requirements
Module: alien_hit_detector

---
 rtl/invaders_pkg.sv | 21 ++
 rtl/alien_hit_detector_if.sv | 15 +
 rtl/alien_hit_detector_priority_pick.sv | 23 ++
 rtl/alien_hit_detector.sv | 151 +++++++++++++++
 tb/tb_alien_hit_detector.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/invaders_pkg.sv
// Shared types and defaults for the alien hit detector.
package invaders_pkg;

   typedef enum logic [1:0] {
      ST_SCAN   = 2'd0,
      ST_REPORT = 2'd1,
      ST_CLEAR  = 2'd2
   } state_t;

   localparam int HIT_POINTS_DEFAULT    = 10;
   localparam int FRAME_END_ROW_DEFAULT = 480;
   localparam int ID_W                  = 3;

   // Score accumulation clamps at the top of the 16-bit range.
   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

endpackage

// File: rtl/alien_hit_detector_if.sv
// Kill-report handshake. hit_valid with stable ids is held by the master until
// the consumer raises hit_ack; the report transfers on the clock edge where both
// are high. hit_ack while hit_valid is low has no effect.
interface alien_hit_detector_if;
   import invaders_pkg::*;

   logic            hit_valid;
   logic [ID_W-1:0] hit_missle_id;
   logic [ID_W-1:0] hit_alien_id;
   logic            hit_ack;

   modport master (output hit_valid, output hit_missle_id, output hit_alien_id, input hit_ack);
   modport slave  (input hit_valid, input hit_missle_id, input hit_alien_id, output hit_ack);

endinterface

// File: rtl/alien_hit_detector_priority_pick.sv
// Lowest-set-bit finder used to choose which alien a missile is credited with.
module priority_pick #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Scan from the top down so the last write wins with the lowest index.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            found = 1'b1;
            idx   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/alien_hit_detector.sv
// Collects missile/alien sprite overlaps during the visible frame, then reports
// one kill per missile during blanking, retiring missiles and killing aliens.
module alien_hit_detector
   import invaders_pkg::*;
#(
   parameter int NUM_MISSLES   = 8,
   parameter int NUM_ALIENS    = 8,
   parameter int FRAME_END_ROW = FRAME_END_ROW_DEFAULT,
   parameter int HIT_POINTS    = HIT_POINTS_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [11:0]            pixel_row,
   input  logic [11:0]            pixel_column,
   input  logic [NUM_MISSLES-1:0] missle_active,
   input  logic [NUM_ALIENS-1:0]  alien_active,
   alien_hit_detector_if.master   hit_if,
   output logic [NUM_MISSLES-1:0] missle_retire,
   output logic [NUM_ALIENS-1:0]  alien_alive,
   output logic [15:0]            score,
   output logic                   fleet_cleared,
   output state_t                 state_dbg
);

   localparam int MW = (NUM_MISSLES > 1) ? $clog2(NUM_MISSLES) : 1;
   localparam int AW = (NUM_ALIENS > 1) ? $clog2(NUM_ALIENS) : 1;

   state_t                                 state_q, state_d;
   logic [NUM_MISSLES-1:0][NUM_ALIENS-1:0] hit_q, hit_d;
   logic [MW-1:0]                          m_q, m_d;
   logic                                   hit_valid_q, hit_valid_d;
   logic [ID_W-1:0]                        missle_id_q, missle_id_d;
   logic [ID_W-1:0]                        alien_id_q, alien_id_d;
   logic [NUM_MISSLES-1:0]                 retire_q, retire_d;
   logic [NUM_ALIENS-1:0]                  alive_q, alive_d;
   logic [15:0]                            score_q, score_d;

   logic                                   pick_found;
   logic [AW-1:0]                          pick_idx;
   logic                                   advance;

   // Candidate aliens for the current missile: its hits that are still alive.
   priority_pick #(.N(NUM_ALIENS), .IW(AW)) u_pick (
      .vec   (hit_q[m_q] & alive_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Next-state and datapath: accumulate hits, walk missiles, apply accepted kills.
   always_comb begin
      state_d     = state_q;
      hit_d       = hit_q;
      m_d         = m_q;
      hit_valid_d = hit_valid_q;
      missle_id_d = missle_id_q;
      alien_id_d  = alien_id_q;
      retire_d    = '0;
      alive_d     = alive_q;
      score_d     = score_q;
      advance     = 1'b0;

      case (state_q)
         ST_SCAN: begin
            for (int m = 0; m < NUM_MISSLES; m++) begin
               for (int a = 0; a < NUM_ALIENS; a++) begin
                  if (missle_active[m] && alien_active[a] && alive_q[a]) begin
                     hit_d[m][a] = 1'b1;
                  end
               end
            end
            if (pixel_row == 12'(FRAME_END_ROW) && pixel_column == 12'd0) begin
               state_d = ST_REPORT;
               m_d     = '0;
            end
         end

         ST_REPORT: begin
            if (hit_valid_q) begin
               // Holding a report; only the consumer's ack moves things on.
               if (hit_if.hit_ack) begin
                  alive_d[alien_id_q] = 1'b0;
                  score_d             = sat_add16(score_q, 16'(HIT_POINTS));
                  retire_d[m_q]       = 1'b1;
                  hit_valid_d         = 1'b0;
                  advance             = 1'b1;
               end
            end else if (pick_found) begin
               hit_valid_d = 1'b1;
               missle_id_d = ID_W'(m_q);
               alien_id_d  = ID_W'(pick_idx);
            end else begin
               advance = 1'b1;
            end

            if (advance) begin
               if (m_q == MW'(NUM_MISSLES - 1)) begin
                  state_d = ST_CLEAR;
                  m_d     = '0;
               end else begin
                  m_d = m_q + 1'b1;
               end
            end
         end

         ST_CLEAR: begin
            hit_d   = '0;
            m_d     = '0;
            state_d = ST_SCAN;
         end

         default: begin
            state_d = ST_SCAN;
         end
      endcase
   end

   // State and datapath registers; reset abandons any pending report.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_SCAN;
         hit_q       <= '0;
         m_q         <= '0;
         hit_valid_q <= 1'b0;
         missle_id_q <= '0;
         alien_id_q  <= '0;
         retire_q    <= '0;
         alive_q     <= '1;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         hit_q       <= hit_d;
         m_q         <= m_d;
         hit_valid_q <= hit_valid_d;
         missle_id_q <= missle_id_d;
         alien_id_q  <= alien_id_d;
         retire_q    <= retire_d;
         alive_q     <= alive_d;
         score_q     <= score_d;
      end
   end

   assign hit_if.hit_valid     = hit_valid_q;
   assign hit_if.hit_missle_id = missle_id_q;
   assign hit_if.hit_alien_id  = alien_id_q;
   assign missle_retire        = retire_q;
   assign alien_alive          = alive_q;
   assign score                = score_q;
   assign fleet_cleared        = ~|alive_q;
   assign state_dbg            = state_q;

endmodule

// File: tb/tb_alien_hit_detector.sv
// Directed bench for alien_hit_detector: frames of sprite overlaps followed by
// the blanking-time kill reports, checked against hand-computed results.
module tb_alien_hit_detector;
   import invaders_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] pixel_row;
   logic [11:0] pixel_column;
   logic [7:0]  missle_active;
   logic [7:0]  alien_active;
   logic [7:0]  missle_retire;
   logic [7:0]  alien_alive;
   logic [15:0] score;
   logic        fleet_cleared;
   state_t      state_dbg;

   alien_hit_detector_if hit_if();

   alien_hit_detector #(
      .NUM_MISSLES   (8),
      .NUM_ALIENS    (8),
      .FRAME_END_ROW (480),
      .HIT_POINTS    (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pixel_row     (pixel_row),
      .pixel_column  (pixel_column),
      .missle_active (missle_active),
      .alien_active  (alien_active),
      .hit_if        (hit_if),
      .missle_retire (missle_retire),
      .alien_alive   (alien_alive),
      .score         (score),
      .fleet_cleared (fleet_cleared),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- report observation results ----------------
   int         rep_n;
   logic [2:0] first_mid, first_aid;
   logic [7:0] retire_or;
   int         retire_cnt;
   int         stab_err;
   int         early_err;
   int         report_guard;

   // Drive a frame: overlap cycles, near-miss end positions, then the trigger.
   task automatic do_frame(input logic [7:0] m, input logic [7:0] a, input int ncyc);
      pixel_row     = 12'd100;
      pixel_column  = 12'd200;
      missle_active = m;
      alien_active  = a;
      repeat (ncyc) step();
      missle_active = '0;
      alien_active  = '0;
      pixel_row     = 12'd480;
      pixel_column  = 12'd1;
      step();
      pixel_row     = 12'd479;
      pixel_column  = 12'd0;
      step();
      chk("no_early_report", 32'(state_dbg), 32'(ST_SCAN));
      pixel_row     = 12'd480;
      pixel_column  = 12'd0;
      step();
      chk("enter_report", 32'(state_dbg), 32'(ST_REPORT));
   endtask

   // Walk the REPORT phase back to SCAN, acking each report after ack_wait
   // extra valid cycles, while driving all-active pixels that must be ignored.
   task automatic run_report(input int ack_wait);
      int         waited;
      logic       pending;
      logic [2:0] cur_mid, cur_aid;
      logic [15:0] score0;
      rep_n = 0; retire_or = '0; retire_cnt = 0; stab_err = 0; early_err = 0;
      first_mid = '0; first_aid = '0; cur_mid = '0; cur_aid = '0;
      pending = 1'b0; waited = 0; report_guard = 0; score0 = score;
      pixel_row = 12'd481; pixel_column = 12'd5;
      missle_active = '1; alien_active = '1;
      while (state_dbg != ST_SCAN && report_guard < 400) begin
         if (missle_retire != 8'h00) begin
            retire_or |= missle_retire;
            retire_cnt++;
         end
         if (hit_if.hit_valid) begin
            if (!pending) begin
               pending = 1'b1;
               waited  = 0;
               cur_mid = hit_if.hit_missle_id;
               cur_aid = hit_if.hit_alien_id;
               if (rep_n == 0) begin
                  first_mid = cur_mid;
                  first_aid = cur_aid;
               end
               rep_n++;
            end else if (hit_if.hit_missle_id != cur_mid || hit_if.hit_alien_id != cur_aid) begin
               stab_err++;
            end
            if (waited < ack_wait) begin
               if (missle_retire != 8'h00 || score != score0) early_err++;
               hit_if.hit_ack = 1'b0;
               waited++;
            end else begin
               hit_if.hit_ack = 1'b1;
            end
         end else begin
            hit_if.hit_ack = 1'b0;
         end
         step();
         report_guard++;
         if (hit_if.hit_ack) begin
            pending        = 1'b0;
            hit_if.hit_ack = 1'b0;
            score0         = score;
         end
      end
      hit_if.hit_ack = 1'b0;
      missle_active  = '0;
      alien_active   = '0;
      chk("report_finished", 32'(report_guard < 400), 32'd1);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]  mact;
      logic [7:0]  aact;
      int          ncyc;
      int          ack_wait;
      int          exp_n;
      logic [2:0]  exp_mid;
      logic [2:0]  exp_aid;
      logic [7:0]  exp_retire;
      logic [7:0]  exp_alive;
      logic [15:0] exp_score;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int seen;
      logic [7:0] ret_acc;
      logic       valid_acc;

      // Cumulative expectations, starting after the first hand-written frame
      // (alien 5 dead, score 10).
      vecs[0] = '{8'h03, 8'h08, 2, 0,  1, 3'd0, 3'd3, 8'h01, 8'hD7, 16'd20}; // shared target
      vecs[1] = '{8'h10, 8'h42, 1, 0,  1, 3'd4, 3'd1, 8'h10, 8'hD5, 16'd30}; // two targets
      vecs[2] = '{8'h01, 8'h20, 1, 0,  0, 3'd0, 3'd0, 8'h00, 8'hD5, 16'd30}; // dead alien only
      vecs[3] = '{8'h00, 8'hFF, 3, 0,  0, 3'd0, 3'd0, 8'h00, 8'hD5, 16'd30}; // no missiles
      vecs[4] = '{8'h80, 8'h80, 1, 0,  1, 3'd7, 3'd7, 8'h80, 8'h55, 16'd40}; // top indices
      vecs[5] = '{8'h03, 8'h55, 1, 1,  2, 3'd0, 3'd0, 8'h03, 8'h50, 16'd60}; // skip killed alien
      vecs[6] = '{8'h08, 8'h10, 1, 20, 1, 3'd3, 3'd4, 8'h08, 8'h40, 16'd70}; // long backpressure
      vecs[7] = '{8'h01, 8'h40, 1, 0,  1, 3'd0, 3'd6, 8'h01, 8'h00, 16'd80}; // last alien
      vecs[8] = '{8'hFF, 8'hFF, 4, 0,  0, 3'd0, 3'd0, 8'h00, 8'h00, 16'd80}; // fleet gone

      rst = 1'b1;
      pixel_row = '0; pixel_column = '0;
      missle_active = '0; alien_active = '0;
      hit_if.hit_ack = 1'b0;
      repeat (2) step();

      chk("rst_valid",  32'(hit_if.hit_valid), 32'd0);
      chk("rst_mid",    32'(hit_if.hit_missle_id), 32'd0);
      chk("rst_aid",    32'(hit_if.hit_alien_id), 32'd0);
      chk("rst_retire", 32'(missle_retire), 32'd0);
      chk("rst_alive",  32'(alien_alive), 32'hFF);
      chk("rst_score",  32'(score), 32'd0);
      chk("rst_fleet",  32'(fleet_cleared), 32'd0);
      chk("rst_state",  32'(state_dbg), 32'(ST_SCAN));
      rst = 1'b0;
      step();

      // Missile 2 over alien 5 for three pixels, ack on the second valid cycle.
      do_frame(8'h04, 8'h20, 3);
      run_report(1);
      chk("f0_reports",    32'(rep_n), 32'd1);
      chk("f0_mid",        32'(first_mid), 32'd2);
      chk("f0_aid",        32'(first_aid), 32'd5);
      chk("f0_retire",     32'(retire_or), 32'h04);
      chk("f0_retire_len", 32'(retire_cnt), 32'd1);
      chk("f0_alive",      32'(alien_alive), 32'hDF);
      chk("f0_score",      32'(score), 32'd10);
      chk("f0_stable",     32'(stab_err), 32'd0);

      for (int i = 0; i < 9; i++) begin
         do_frame(vecs[i].mact, vecs[i].aact, vecs[i].ncyc);
         run_report(vecs[i].ack_wait);
         chk($sformatf("v%0d_reports", i), 32'(rep_n), 32'(vecs[i].exp_n));
         if (vecs[i].exp_n > 0) begin
            chk($sformatf("v%0d_mid", i), 32'(first_mid), 32'(vecs[i].exp_mid));
            chk($sformatf("v%0d_aid", i), 32'(first_aid), 32'(vecs[i].exp_aid));
         end
         chk($sformatf("v%0d_retire", i),     32'(retire_or), 32'(vecs[i].exp_retire));
         chk($sformatf("v%0d_retire_len", i), 32'(retire_cnt), 32'(vecs[i].exp_n));
         chk($sformatf("v%0d_alive", i),      32'(alien_alive), 32'(vecs[i].exp_alive));
         chk($sformatf("v%0d_score", i),      32'(score), 32'(vecs[i].exp_score));
         chk($sformatf("v%0d_fleet", i),      32'(fleet_cleared), 32'(vecs[i].exp_alive == 8'h00));
         chk($sformatf("v%0d_stable", i),     32'(stab_err), 32'd0);
         chk($sformatf("v%0d_no_early", i),   32'(early_err), 32'd0);
      end

      // Reset while a report is pending.
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("r2_alive", 32'(alien_alive), 32'hFF);
      chk("r2_score", 32'(score), 32'd0);
      do_frame(8'h40, 8'h04, 1);
      pixel_row = 12'd481; pixel_column = 12'd5;
      seen = 0;
      for (int k = 0; k < 30 && seen == 0; k++) begin
         if (hit_if.hit_valid) seen = 1;
         else step();
      end
      chk("r2_valid_seen", 32'(seen), 32'd1);
      chk("r2_mid", 32'(hit_if.hit_missle_id), 32'd6);
      chk("r2_aid", 32'(hit_if.hit_alien_id), 32'd2);
      rst = 1'b1;
      step();
      chk("r2_valid",  32'(hit_if.hit_valid), 32'd0);
      chk("r2_mid0",   32'(hit_if.hit_missle_id), 32'd0);
      chk("r2_aid0",   32'(hit_if.hit_alien_id), 32'd0);
      chk("r2_retire", 32'(missle_retire), 32'd0);
      chk("r2_alive2", 32'(alien_alive), 32'hFF);
      chk("r2_score2", 32'(score), 32'd0);
      chk("r2_state",  32'(state_dbg), 32'(ST_SCAN));
      rst = 1'b0;
      ret_acc = '0;
      valid_acc = 1'b0;
      repeat (12) begin
         step();
         ret_acc   |= missle_retire;
         valid_acc |= hit_if.hit_valid;
      end
      chk("r2_no_retire", 32'(ret_acc), 32'd0);
      chk("r2_no_valid",  32'(valid_acc), 32'd0);
      chk("r2_score3",    32'(score), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
